fifo_write_arbiter: RTL and testbench
=====================================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter MAX_BURST, default 4, maximum words accepted per grant; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 res  input  1  reset, synchronous, active-high.
REQ-005 req0  input  1  requester 0 has a word on wdata0.
REQ-006 wdata0  input  WIDTH  requester 0 data.
REQ-007 req1  input  1  requester 1 has a word on wdata1.
REQ-008 wdata1  input  WIDTH  requester 1 data.
REQ-009 full  input  1  downstream FIFO full flag.
REQ-010 gnt0  output  1  requester 0 word accepted this cycle.
REQ-011 gnt1  output  1  requester 1 word accepted this cycle.
REQ-012 shift_in  output  1  write strobe to downstream FIFO.
REQ-013 wdata  output  WIDTH  write data to downstream FIFO.
REQ-014 owner  output  2  state: 2'b00 IDLE, 2'b01 OWN0, 2'b10 OWN1.

Function
REQ-015 The block SHALL be a three-state FSM (IDLE, OWN0, OWN1) with a registered burst counter (8 bits) and a registered last-served pointer (1 bit).
REQ-016 Accept for x: acc_x = (owner==OWNx) & req_x & ~full, combinational.
REQ-017 gnt_x = acc_x; shift_in = acc0 | acc1; at most one asserted per cycle.
REQ-018 wdata = wdata0 in OWN0, wdata1 in OWN1, all-zero in IDLE, combinational.
REQ-019 IDLE: no accepts; if exactly one req, next state = its OWN; if both, next state = OWN of requester not equal to last-served; if none, stay IDLE.
REQ-020 Arbitration latency: a request raised in IDLE is first accepted in the cycle after the request is sampled.
REQ-021 OWNx with acc_x: burst counter increments; if counter == MAX_BURST-1, release.
REQ-022 OWNx with req_x low: release immediately (no accept that cycle).
REQ-023 OWNx with req_x high and full high: hold state and counter; no accept; no release.
REQ-024 On release from OWNx: last-served := x; counter := 0; next state = OWN of other requester if its req high, else OWNx if req_x still high (burst-limit release only), else IDLE.
REQ-025 Hand-over between owners SHALL insert no idle cycle.
REQ-026 Requesters SHALL hold wdata_x stable while req_x is high and gnt_x is low; block does not check this.
REQ-027 Requester dropping req_x mid-burst forfeits the remaining burst; no data is written for that cycle.

Reset
REQ-028 With res high at a clock edge: owner = IDLE, counter = 0, last-served = 1 (requester 0 wins the first tie).
REQ-029 During and after reset, gnt0, gnt1, shift_in = 0 and wdata = 0 until state leaves IDLE.
REQ-030 Reset mid-burst SHALL abort the burst; no write occurs in the reset cycle.

Configuration
REQ-031 Macro FIFO_ARB_STALL_CNT_EN defined: extra output stall_cnt (16 bits) counts cycles with owner != IDLE, owning req high and full high; saturates at 16'hFFFF; cleared by res.
REQ-032 Macro undefined: port stall_cnt and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 Reset, then req0=1 only, full=0, wdata0=8'hA5: cycle 1 owner=OWN0, gnt0=1, shift_in=1, wdata=8'hA5; 4 consecutive accepts, then re-grant OWN0 with counter 0, no gap.
REQ-034 req0=req1=1 constant, full=0, MAX_BURST=4: accept pattern 4×gnt0, 4×gnt1, 4×gnt0; no idle cycle between bursts.
REQ-035 OWN1 after 2 accepts, full=1 for 3 cycles: no gnt, owner=OWN1, counter holds 2; full=0 then 2 more accepts before hand-over; stall_cnt=3 with FIFO_ARB_STALL_CNT_EN.
REQ-036 OWN0, req0 drops after 1 accept while req1=1: next cycle owner=OWN1, last-served=0; gnt1 follows.
REQ-037 res=1 asserted mid-burst in OWN1: same cycle shift_in=0 after edge, owner=IDLE, counter=0; with both reqs high afterwards requester 0 granted first.
REQ-038 All tests: shift_in never 1 when full=1; gnt0 & gnt1 never both 1.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Two-requester write arbiter in front of a FIFO: round-robin grants with a burst limit.
// Optional FIFO_ARB_STALL_CNT_EN adds a saturating stall_cnt output.
module fifo_write_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             req0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             req1,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             full,
  output logic             gnt0,
  output logic             gnt1,
  output logic             shift_in,
  output logic [WIDTH-1:0] wdata,
  output logic [1:0]       owner
`ifdef FIFO_ARB_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             acc0, acc1;
  logic [WIDTH-1:0] wdata_mux;

  // State, burst counter and last-served pointer
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    acc0      = 1'b0;
    acc1      = 1'b0;
    wdata_mux = '0;
    case (state_q)
      IDLE: begin
        // On a tie the requester that was not served last wins
        if (req0 && (!req1 || last_q)) state_d = OWN0;
        else if (req1)                 state_d = OWN1;
      end
      OWN0: begin
        wdata_mux = wdata0;
        if (!req0) begin
          last_d  = 1'b0;
          cnt_d   = '0;
          state_d = req1 ? OWN1 : IDLE;
        end else if (!full) begin
          acc0 = 1'b1;
          if (cnt_q == CNT_LAST) begin
            last_d  = 1'b0;
            cnt_d   = '0;
            state_d = req1 ? OWN1 : OWN0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      OWN1: begin
        wdata_mux = wdata1;
        if (!req1) begin
          last_d  = 1'b1;
          cnt_d   = '0;
          state_d = req0 ? OWN0 : IDLE;
        end else if (!full) begin
          acc1 = 1'b1;
          if (cnt_q == CNT_LAST) begin
            last_d  = 1'b1;
            cnt_d   = '0;
            state_d = req0 ? OWN0 : OWN1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset suppresses any write in the cycle it is asserted
  assign gnt0     = acc0 & ~res;
  assign gnt1     = acc1 & ~res;
  assign shift_in = (acc0 | acc1) & ~res;
  assign wdata    = res ? '0 : wdata_mux;
  assign owner    = state_q;

`ifdef FIFO_ARB_STALL_CNT_EN
  logic stall;
  assign stall = full & (((state_q == OWN0) & req0) | ((state_q == OWN1) & req1));

  // Saturating count of cycles the owner was blocked by a full FIFO
  always_ff @(posedge clk) begin
    if (res)                               stall_cnt <= '0;
    else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed, table-driven bench for fifo_write_arbiter (default WIDTH=8, MAX_BURST=4).
module tb_fifo_write_arbiter;

  logic       clk = 1'b0;
  logic       res, req0, req1, full;
  logic [7:0] wdata0, wdata1, wdata;
  logic       gnt0, gnt1, shift_in;
  logic [1:0] owner;
`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .res(res), .req0(req0), .wdata0(wdata0), .req1(req1), .wdata1(wdata1),
    .full(full), .gnt0(gnt0), .gnt1(gnt1), .shift_in(shift_in), .wdata(wdata), .owner(owner)
`ifdef FIFO_ARB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    logic       res, req0, req1, full;
    logic [7:0] wd0, wd1;
    logic       g0, g1, sh;
    logic [7:0] wd;
    logic [1:0] own;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic r0, input logic r1, input logic f,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic g0, input logic g1, input logic sh,
                              input logic [7:0] wd, input logic [1:0] own);
    vec_t v;
    v.res = r; v.req0 = r0; v.req1 = r1; v.full = f; v.wd0 = d0; v.wd1 = d1;
    v.g0 = g0; v.g1 = g1; v.sh = sh; v.wd = wd; v.own = own;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic invariants(input string tag);
    chk({tag, " shift_with_full"}, 16'(shift_in & full), 16'd0);
    chk({tag, " both_gnt"}, 16'(gnt0 & gnt1), 16'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  n_g0;
  bit  seen_g1;

  initial begin
    res = 1'b1; req0 = 1'b0; req1 = 1'b0; full = 1'b0; wdata0 = '0; wdata1 = '0;
    tick();

    // reset, then single requester 0 with burst re-grant
    add(1,0,0,0, 8'hA5,8'h3C, 0,0,0, 8'h00, 2'b00);
    add(0,1,0,0, 8'hA5,8'h3C, 0,0,0, 8'h00, 2'b00);
    add(0,1,0,0, 8'hA5,8'h3C, 1,0,1, 8'hA5, 2'b01);
    add(0,1,0,0, 8'hA6,8'h3C, 1,0,1, 8'hA6, 2'b01);
    add(0,1,0,0, 8'hA7,8'h3C, 1,0,1, 8'hA7, 2'b01);
    add(0,1,0,0, 8'hA8,8'h3C, 1,0,1, 8'hA8, 2'b01);
    add(0,1,0,0, 8'h5A,8'h3C, 1,0,1, 8'h5A, 2'b01);
    add(0,0,0,0, 8'h5A,8'h3C, 0,0,0, 8'h5A, 2'b01);
    add(0,0,0,0, 8'h5A,8'h3C, 0,0,0, 8'h00, 2'b00);
    // reset, then both requesting: 4 x gnt0, 4 x gnt1, 4 x gnt0
    add(1,1,1,0, 8'h11,8'h22, 0,0,0, 8'h00, 2'b00);
    add(0,1,1,0, 8'h11,8'h22, 0,0,0, 8'h00, 2'b00);
    for (int i = 0; i < 4; i++) add(0,1,1,0, 8'h11,8'h22, 1,0,1, 8'h11, 2'b01);
    for (int i = 0; i < 4; i++) add(0,1,1,0, 8'h11,8'h22, 0,1,1, 8'h22, 2'b10);
    for (int i = 0; i < 4; i++) add(0,1,1,0, 8'h11,8'h22, 1,0,1, 8'h11, 2'b01);
    // OWN1: 2 accepts, 3 full cycles, 2 accepts, hand-over to OWN0
    for (int i = 0; i < 2; i++) add(0,1,1,0, 8'h11,8'h22, 0,1,1, 8'h22, 2'b10);
    for (int i = 0; i < 3; i++) add(0,1,1,1, 8'h11,8'h22, 0,0,0, 8'h22, 2'b10);
    for (int i = 0; i < 2; i++) add(0,1,1,0, 8'h11,8'h22, 0,1,1, 8'h22, 2'b10);
    add(0,1,1,0, 8'h11,8'h22, 1,0,1, 8'h11, 2'b01);
    // req0 drops mid-burst: forfeit, OWN1 next cycle
    add(0,0,1,0, 8'h11,8'h22, 0,0,0, 8'h11, 2'b01);
    add(0,0,1,0, 8'h11,8'h22, 0,1,1, 8'h22, 2'b10);
    add(0,0,1,0, 8'h11,8'h22, 0,1,1, 8'h22, 2'b10);
    // reset mid-burst in OWN1, then tie goes to requester 0
    add(1,1,1,0, 8'h11,8'h22, 0,0,0, 8'h00, 2'b10);
    add(0,1,1,0, 8'h11,8'h22, 0,0,0, 8'h00, 2'b00);
    add(0,1,1,0, 8'h11,8'h22, 1,0,1, 8'h11, 2'b01);
    add(0,0,1,0, 8'h11,8'h22, 0,0,0, 8'h11, 2'b01);
    add(0,0,1,1, 8'h11,8'h22, 0,0,0, 8'h22, 2'b10);
    add(0,0,1,0, 8'h11,8'h22, 0,1,1, 8'h22, 2'b10);

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("v%0d", i);
      res = vecs[i].res; req0 = vecs[i].req0; req1 = vecs[i].req1; full = vecs[i].full;
      wdata0 = vecs[i].wd0; wdata1 = vecs[i].wd1;
      @(negedge clk);
      chk({t, " gnt0"},     16'(gnt0),     16'(vecs[i].g0));
      chk({t, " gnt1"},     16'(gnt1),     16'(vecs[i].g1));
      chk({t, " shift_in"}, 16'(shift_in), 16'(vecs[i].sh));
      chk({t, " wdata"},    16'(wdata),    16'(vecs[i].wd));
      chk({t, " owner"},    16'(owner),    16'(vecs[i].own));
      invariants(t);
`ifdef FIFO_ARB_STALL_CNT_EN
      if (i == 28) chk({t, " stall_cnt"}, stall_cnt, 16'd3);
`endif
      tick();
    end

    // Request under full from IDLE: ownership taken, writes wait, then a full burst
    res = 1'b1; req0 = 1'b1; req1 = 1'b1; full = 1'b1; wdata0 = 8'h77; wdata1 = 8'h88;
    tick();
    res = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d owner", i), 16'(owner), 16'(2'b01));
      chk($sformatf("hold%0d shift_in", i), 16'(shift_in), 16'd0);
      tick();
    end
    full = 1'b0;
    n_g0 = 0;
    seen_g1 = 1'b0;
    for (int i = 0; i < 20 && !seen_g1; i++) begin
      @(negedge clk);
      invariants($sformatf("burst%0d", i));
      if (gnt1) seen_g1 = 1'b1;
      else if (gnt0) n_g0++;
      tick();
    end
    chk("burst_handover_seen", 16'(seen_g1), 16'd1);
    chk("burst_gnt0_count", 16'(n_g0), 16'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
